// File: rtl/acq_write_enable_pkg.sv
// Shared types and default widths for the ADC acquisition write-enable generator.
package acq_write_enable_pkg;

  localparam int unsigned DEF_ADDR_WIDTH  = 13;
  localparam int unsigned DEF_DELAY_WIDTH = 16;
  localparam int unsigned DEF_COUNT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_DELAY = 2'd2,
    ST_WRITE = 2'd3
  } acq_state_t;

endpackage

// File: rtl/acq_write_enable_down_counter.sv
// Loadable down counter that holds at zero; used for arm timer, delay and window length.
module acq_down_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero_c
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/acq_write_enable.sv
// BRAM write-enable generator: arm on start, sync to address wrap, delay, then write a window.
module acq_write_enable
  import acq_write_enable_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned DELAY_WIDTH = DEF_DELAY_WIDTH,
  parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_acq,
  input  logic                   stop_acq,
  input  logic                   continuous,
  input  logic [ADDR_WIDTH-1:0]  address,
  input  logic [ADDR_WIDTH:0]    acq_len,
  input  logic [DELAY_WIDTH-1:0] delay,
  output logic                   wen,
  output logic [ADDR_WIDTH-1:0]  wen_index,
  output logic                   busy,
  output logic                   timeout,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] acq_count
);

  localparam int unsigned LEN_W = ADDR_WIDTH + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  acq_state_t             r_state;
  logic [ADDR_WIDTH-1:0]  r_len_m1;
  logic [DELAY_WIDTH-1:0] r_delay;
  logic                   r_cont;
  logic                   r_stop_pend;
  logic                   r_wen;
  logic [ADDR_WIDTH-1:0]  r_wen_index;
  logic                   r_busy;
  logic                   r_timeout;
  logic                   r_done;
  logic [COUNT_WIDTH-1:0] r_acq_count;

  logic                   w_start;
  logic                   w_sync;
  logic                   w_rearm;
  logic [ADDR_WIDTH-1:0]  w_len_m1_in;
  logic                   w_arm_load, w_arm_dec, w_arm_zero;
  logic                   w_dly_load, w_dly_dec, w_dly_zero;
  logic                   w_len_load, w_len_dec, w_len_zero;

  assign w_start = start_acq & ~stop_acq;
  assign w_sync  = (address == '0);
  assign w_rearm = r_cont & ~r_stop_pend & ~stop_acq;

  // Zero or oversize lengths select the full 2**ADDR_WIDTH window.
  assign w_len_m1_in = ((acq_len == '0) || (acq_len > MAX_LEN)) ? '1
                     : ADDR_WIDTH'(acq_len - LEN_W'(1));

  always_comb begin
    w_arm_load = 1'b0;
    w_arm_dec  = 1'b0;
    w_dly_load = 1'b0;
    w_dly_dec  = 1'b0;
    w_len_load = 1'b0;
    w_len_dec  = 1'b0;
    case (r_state)
      ST_IDLE:  w_arm_load = w_start;
      ST_ARM: begin
        if (!stop_acq) begin
          if (w_sync) begin
            w_len_load = (r_delay == '0);
            w_dly_load = (r_delay != '0);
          end else begin
            w_arm_dec = 1'b1;
          end
        end
      end
      ST_DELAY: begin
        if (!stop_acq) begin
          w_len_load = w_dly_zero;
          w_dly_dec  = ~w_dly_zero;
        end
      end
      ST_WRITE: begin
        w_arm_load = w_len_zero & w_rearm;
        w_len_dec  = ~w_len_zero;
      end
      default: ;
    endcase
  end

  acq_down_counter #(.WIDTH(ADDR_WIDTH)) u_arm_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_arm_load),
    .i_load_val ('1),
    .i_dec      (w_arm_dec),
    .o_zero_c   (w_arm_zero)
  );

  acq_down_counter #(.WIDTH(DELAY_WIDTH)) u_delay (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_dly_load),
    .i_load_val (r_delay - DELAY_WIDTH'(1)),
    .i_dec      (w_dly_dec),
    .o_zero_c   (w_dly_zero)
  );

  acq_down_counter #(.WIDTH(ADDR_WIDTH)) u_length (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_len_load),
    .i_load_val (r_len_m1),
    .i_dec      (w_len_dec),
    .o_zero_c   (w_len_zero)
  );

  // Every edge spent in WRITE emits one registered wen sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_len_m1    <= '0;
      r_delay     <= '0;
      r_cont      <= 1'b0;
      r_stop_pend <= 1'b0;
      r_wen       <= 1'b0;
      r_wen_index <= '0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
      r_done      <= 1'b0;
      r_acq_count <= '0;
    end else begin
      r_wen       <= 1'b0;
      r_done      <= 1'b0;
      r_wen_index <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state     <= ST_ARM;
            r_busy      <= 1'b1;
            r_len_m1    <= w_len_m1_in;
            r_delay     <= delay;
            r_cont      <= continuous;
            r_timeout   <= 1'b0;
            r_acq_count <= '0;
            r_stop_pend <= 1'b0;
          end
        end
        ST_ARM: begin
          if (stop_acq) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_sync) begin
            r_state <= (r_delay == '0) ? ST_WRITE : ST_DELAY;
          end else if (w_arm_zero) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
          end
        end
        ST_DELAY: begin
          if (stop_acq) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_dly_zero) begin
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_wen       <= 1'b1;
          r_wen_index <= r_wen ? r_wen_index + ADDR_WIDTH'(1) : '0;
          if (stop_acq) r_stop_pend <= 1'b1;
          if (w_len_zero) begin
            r_done      <= 1'b1;
            r_acq_count <= r_acq_count + COUNT_WIDTH'(1);
            r_stop_pend <= 1'b0;
            if (w_rearm) begin
              r_state <= ST_ARM;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wen       = r_wen;
  assign wen_index = r_wen_index;
  assign busy      = r_busy;
  assign timeout   = r_timeout;
  assign done      = r_done;
  assign acq_count = r_acq_count;

endmodule

// File: tb/tb_acq_write_enable.sv
// Scenario bench for acq_write_enable with a queue of expected wen samples (ADDR_WIDTH=4).
module tb_acq_write_enable;

  logic        clk;
  logic        rst;
  logic        start_acq;
  logic        stop_acq;
  logic        continuous;
  logic [3:0]  address;
  logic [4:0]  acq_len;
  logic [7:0]  delay;
  logic        wen;
  logic [3:0]  wen_index;
  logic        busy;
  logic        timeout;
  logic        done;
  logic [31:0] acq_count;

  typedef struct {
    int cyc;
    int idx;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   errors   = 0;
  bit   addr_run = 1'b1;

  acq_write_enable #(
    .ADDR_WIDTH  (4),
    .DELAY_WIDTH (8),
    .COUNT_WIDTH (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_acq  (start_acq),
    .stop_acq   (stop_acq),
    .continuous (continuous),
    .address    (address),
    .acq_len    (acq_len),
    .delay      (delay),
    .wen        (wen),
    .wen_index  (wen_index),
    .busy       (busy),
    .timeout    (timeout),
    .done       (done),
    .acq_count  (acq_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge, move the free-running address, and consume expected wen samples.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (addr_run) address = address + 4'd1;
    if (wen === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_wen cyc=%0d idx=%0d done=%0d", cyc, wen_index, done);
      end else begin
        e = exp_q.pop_front();
        if (cyc !== e.cyc || wen_index !== 4'(e.idx) || done !== e.last) begin
          errors++;
          $display("FAIL wen_sample got cyc=%0d idx=%0d done=%0d expected cyc=%0d idx=%0d done=%0d",
                   cyc, wen_index, done, e.cyc, e.idx, e.last);
        end
      end
    end else if (done !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL done_without_wen cyc=%0d done=%0d expected 0", cyc, done);
    end
  endtask

  task automatic push_window(input int first, input int len);
    for (int i = 0; i < len; i++) exp_q.push_back('{cyc: first + i, idx: i, last: (i == len - 1)});
  endtask

  // Issue a start with address a seen on the start edge; k is the edge where address 0 is next seen.
  task automatic do_start(input int len, input int dly, input bit cont, input int a,
                          output int s, output int k);
    int j;
    acq_len    = 5'(len);
    delay      = 8'(dly);
    continuous = cont;
    address    = 4'(a);
    start_acq  = 1'b1;
    step();
    s = cyc;
    start_acq = 1'b0;
    j = (16 - a) % 16;
    if (j == 0) j = 16;
    k = s + j;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (wen !== 1'b0)        begin errors++; $display("FAIL reset_wen got %0b expected 0", wen); end
    checks++; if (wen_index !== 4'd0)  begin errors++; $display("FAIL reset_idx got %0d expected 0", wen_index); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %0b expected 0", busy); end
    checks++; if (timeout !== 1'b0)    begin errors++; $display("FAIL reset_timeout got %0b expected 0", timeout); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got %0b expected 0", done); end
    checks++; if (acq_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", acq_count); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_full_window();
    int s, k;
    addr_run = 1'b1;
    do_start(0, 0, 0, 11, s, k);
    push_window(k + 1, 16);
    while (cyc < k + 1) step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy_during got %0b expected 1", busy); end
    while (cyc < k + 18) step();
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL full_busy_after got %0b expected 0", busy); end
    checks++; if (acq_count !== 32'd1) begin errors++; $display("FAIL full_count got %0d expected 1", acq_count); end
    checks++; if (wen_index !== 4'd0)  begin errors++; $display("FAIL full_idx_after got %0d expected 0", wen_index); end
    checks++; if (exp_q.size() != 0)   begin errors++; $display("FAIL full_missing got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_delay_window();
    int s, k;
    do_start(5, 3, 0, 6, s, k);
    push_window(k + 4, 5);
    acq_len = 5'd9;
    delay   = 8'd0;
    while (cyc < k + 12) begin
      start_acq = (cyc == s + 3);
      step();
    end
    start_acq = 1'b0;
    checks++; if (acq_count !== 32'd1) begin errors++; $display("FAIL delay_count got %0d expected 1", acq_count); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL delay_busy got %0b expected 0", busy); end
    checks++; if (exp_q.size() != 0)   begin errors++; $display("FAIL delay_missing got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    int s, k;
    addr_run = 1'b0;
    do_start(4, 0, 0, 3, s, k);
    while (cyc < s + 15) step();
    checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL tmo_busy_pre got %0b expected 1", busy); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_flag_pre got %0b expected 0", timeout); end
    step();
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL tmo_busy got %0b expected 0", busy); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_flag got %0b expected 1", timeout); end
    repeat (4) step();
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %0b expected 1", timeout); end
    addr_run = 1'b1;
    do_start(1, 0, 0, 14, s, k);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_clear got %0b expected 0", timeout); end
    push_window(k + 1, 1);
    while (cyc < k + 4) step();
    checks++; if (acq_count !== 32'd1) begin errors++; $display("FAIL len1_count got %0d expected 1", acq_count); end
    checks++; if (exp_q.size() != 0)   begin errors++; $display("FAIL len1_missing got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_continuous();
    int s, k;
    addr_run = 1'b1;
    do_start(4, 0, 1, 2, s, k);
    push_window(k + 1, 4);
    push_window(k + 17, 4);
    push_window(k + 33, 4);
    while (cyc < k + 60) begin
      step();
      stop_acq = (cyc == k + 33);
      if (cyc == k + 5) begin
        checks++; if (acq_count !== 32'd1) begin errors++; $display("FAIL cont_count1 got %0d expected 1", acq_count); end
      end
      if (cyc == k + 10) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cont_busy_gap got %0b expected 1", busy); end
      end
      if (cyc == k + 21) begin
        checks++; if (acq_count !== 32'd2) begin errors++; $display("FAIL cont_count2 got %0d expected 2", acq_count); end
      end
      if (cyc == k + 37) begin
        checks++; if (acq_count !== 32'd3) begin errors++; $display("FAIL cont_count3 got %0d expected 3", acq_count); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL cont_stop_idle got %0b expected 0", busy); end
      end
    end
    continuous = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL cont_missing got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_abort();
    int s, k;
    // stop while armed
    addr_run = 1'b0;
    do_start(4, 0, 0, 5, s, k);
    step();
    step();
    stop_acq = 1'b1;
    step();
    stop_acq = 1'b0;
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL stop_arm_busy got %0b expected 0", busy); end
    checks++; if (acq_count !== 32'd0) begin errors++; $display("FAIL stop_arm_count got %0d expected 0", acq_count); end
    checks++; if (timeout !== 1'b0)    begin errors++; $display("FAIL stop_arm_tmo got %0b expected 0", timeout); end
    repeat (20) step();
    // stop while delaying
    addr_run = 1'b1;
    do_start(4, 10, 0, 14, s, k);
    while (cyc < s + 3) step();
    stop_acq = 1'b1;
    step();
    stop_acq = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_dly_busy got %0b expected 0", busy); end
    repeat (30) step();
    checks++; if (acq_count !== 32'd0) begin errors++; $display("FAIL stop_dly_count got %0d expected 0", acq_count); end
    // start and stop together
    start_acq = 1'b1;
    stop_acq  = 1'b1;
    step();
    start_acq = 1'b0;
    stop_acq  = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_busy got %0b expected 0", busy); end
    repeat (5) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_idle got %0b expected 0", busy); end
    // asynchronous reset in the middle of a window
    do_start(0, 0, 0, 14, s, k);
    push_window(k + 1, 16);
    while (cyc < k + 4) step();
    #3;
    rst = 1'b1;
    #1;
    checks++; if (wen !== 1'b0)        begin errors++; $display("FAIL arst_wen got %0b expected 0", wen); end
    checks++; if (wen_index !== 4'd0)  begin errors++; $display("FAIL arst_idx got %0d expected 0", wen_index); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL arst_busy got %0b expected 0", busy); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL arst_done got %0b expected 0", done); end
    checks++; if (acq_count !== 32'd0) begin errors++; $display("FAIL arst_count got %0d expected 0", acq_count); end
    checks++; if (timeout !== 1'b0)    begin errors++; $display("FAIL arst_tmo got %0b expected 0", timeout); end
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
    repeat (20) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_idle got %0b expected 0", busy); end
  endtask

  initial begin
    rst        = 1'b1;
    start_acq  = 1'b0;
    stop_acq   = 1'b0;
    continuous = 1'b0;
    address    = 4'd0;
    acq_len    = 5'd0;
    delay      = 8'd0;
    test_reset();
    test_full_window();
    test_delay_window();
    test_timeout();
    test_continuous();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
